out_sram_axi_writer: RTL and testbench
======================================

Name: out_sram_axi_writer

Overview:
AXI4 write-master (initiator) that drains the EPU output SRAM to system memory. On start it reads len_words 32-bit words from the local SRAM port, beginning at word index src_addr. It issues INCR write bursts to byte address dst_addr and reports done when the last B response is accepted. It sits beside the output SRAM wrapper: that wrapper is the AXI responder, this block is the initiator driving the opposite end of the same protocol.

Parameters:
MAX_BEATS, 16, maximum beats per burst (AWLEN max = MAX_BEATS-1; must be ≤ 16)
SRAM_AW, 12, SRAM word-address width
AXI_ID, 4'd0, constant AWID value

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, accepted only in IDLE
src_addr  in  SRAM_AW  first SRAM word index
dst_addr  in  32  destination byte address, word aligned (bits[1:0] ignored)
len_words  in  16  number of 32-bit words to move
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when transfer completes
err  out  1  sticky: any BRESP≠OKAY seen; cleared on next accepted start
sram_a  out  SRAM_AW  SRAM read address
sram_do  in  32  SRAM read data, valid exactly 1 cycle after sram_a presented
AWID  out  4  =AXI_ID
AWADDR  out  32  burst start address
AWLEN  out  4  beats-1
AWSIZE  out  3  fixed 3'b010
AWBURST  out  2  fixed 2'b01 (INCR)
AWVALID  out  1  address valid
AWREADY  in  1  address ready
WDATA  out  32  write data
WSTRB  out  4  fixed 4'hF
WLAST  out  1  last beat of burst
WVALID  out  1  data valid
WREADY  in  1  data ready
BID  in  4  ignored
BRESP  in  2  write response
BVALID  in  1  response valid
BREADY  out  1  response ready

Behaviour:
- Reset (RSTn=0 at posedge): state IDLE; busy, done, err, AWVALID, WVALID, WLAST, BREADY = 0; AWADDR, AWLEN, sram_a = 0; FIFO emptied. Reset mid-transfer aborts immediately with no protocol completion; reset is system-wide.
- FSM states: IDLE → AW → W → B → (AW if words remain, else DONE) → IDLE.
- IDLE: on start, latch src/dst/len and clear err. If len_words=0, go to DONE: done pulses the next cycle and no AXI traffic occurs. start while not IDLE is ignored.
- Burst sizing at AW entry: beats = min(remaining, MAX_BEATS, (4096 − cur_addr[11:0])/4). Bursts never cross a 4 KB boundary. AWLEN = beats−1.
- AW: AWVALID held until AWREADY. AWADDR and AWLEN remain stable while AWVALID=1.
- W: entered after the AW handshake. No W beat is issued before its AW is accepted.
- SRAM prefetch:
  - A read is issued (sram_a = rd_ptr) in any W-state cycle with fifo_count + inflight < 2 and fetched < beats; rd_ptr then increments.
  - Data is written into a 2-entry FIFO the following cycle.
  - Prefetch may also begin in the AW state.
- Write data path: WVALID = FIFO non-empty and WDATA = FIFO head. A beat transfers on WVALID&WREADY. WLAST = 1 on beat index beats−1. WREADY held low stalls without data loss or duplication.
- B: BREADY = 1 in state B. On BVALID, if BRESP≠2'b00 set err. Then advance dst by beats*4 and decrement remaining.
- DONE: done = 1 for exactly one cycle; busy drops the same cycle; return to IDLE.
- SRAM address wraps modulo 2^SRAM_AW. Destination address wraps modulo 2^32.
- Throughput target: one beat per cycle with WREADY constantly high after the first beat of each burst.

Optional Feature:
OSW_PERF_CNT_EN
- Defined: adds outputs perf_stall[31:0] and perf_cycles[31:0].
  - perf_stall counts cycles with WVALID&!WREADY or AWVALID&!AWREADY.
  - perf_cycles counts busy cycles.
  - Both clear on accepted start; both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package osw_pkg:
  - state enum {IDLE, AW, W, B, DONE}
  - AXI_SIZE_4B = 3'b010, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00
  - beat-count function min3()
- One sub-module: osw_fifo2, a 2-entry FIFO with count output, used for SRAM read-latency decoupling.

Test Plan:
1. len=5, src=0x010, dst=0x1000, always-ready slave → one burst AWLEN=4, WDATA = SRAM[0x010..0x014], WLAST on beat 5, done pulse, err=0.
2. len=40, dst=0x0 → bursts AWLEN=15,15,7 at AWADDR 0x0, 0x40, 0x80; 40 beats total, in order.
3. dst=0xFF8, len=6 → bursts AWLEN=1 at 0xFF8, then AWLEN=3 at 0x1000 (no 4 KB crossing).
4. Random WREADY/AWREADY/BVALID backpressure (≈50%), len=33 → every SRAM word written exactly once, in order, with stable WDATA during stalls.
5. BRESP=2'b10 on the 2nd of 3 bursts → transfer completes, err=1 after done; next start clears err. len=0 → done one cycle after start, no AWVALID.
6. RSTn low mid-W-burst → next cycle all valids and busy are 0; a new start after reset runs correctly.

Source files
------------

// File: rtl/osw_pkg.sv
// -----------------------------------------------------------------------------
// osw_pkg
// Shared types and constants for out_sram_axi_writer and its sub-module.
//   osw_state_e : writer FSM states
//   AXI_*       : fixed AXI4 encodings driven by the writer
//   min3()      : smallest of three beat-count candidates
// -----------------------------------------------------------------------------
package osw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        DONE
    } osw_state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Burst length = min(words remaining, max burst, words left in 4 KB page).
    function automatic logic [15:0] min3(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/osw_fifo2.sv
// -----------------------------------------------------------------------------
// osw_fifo2
// Two-entry FIFO that absorbs the one-cycle SRAM read latency between the
// prefetcher and the AXI W channel. Push and pop may occur in the same cycle.
// The writer never pushes into a full FIFO, so no overflow guard is needed.
//   clk_i, rst_ni : clock, synchronous active-low reset (empties the FIFO)
//   push_i/data_i : write one entry
//   pop_i         : discard head entry
//   data_o        : head entry (valid when count_o != 0)
//   count_o       : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module osw_fifo2 #(
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    cnt_q;

    // NOTE: storage has no reset; only pointers and count need a known state.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) wr_q <= ~wr_q;
            if (pop_i)  rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/out_sram_axi_writer.sv
// -----------------------------------------------------------------------------
// out_sram_axi_writer
// AXI4 write initiator that copies len_words 32-bit words from the local
// output SRAM (starting at word src_addr) to system memory at byte address
// dst_addr, using INCR bursts that never cross a 4 KB boundary.
//
// Ports:
//   CLK, RSTn            : clock, synchronous active-low reset
//   start                : one-cycle request pulse, honoured only when idle
//   src_addr, dst_addr,
//   len_words            : transfer descriptor
//   busy, done, err      : status (err sticky until the next accepted start)
//   sram_a, sram_do      : SRAM read port, data one cycle after address
//   AW*, W*, B*          : AXI4 write channels (initiator side)
//
// Optional build macro OSW_PERF_CNT_EN adds perf_stall / perf_cycles
// counters (stalled handshake cycles and busy cycles of the last transfer).
// -----------------------------------------------------------------------------
module out_sram_axi_writer
    import osw_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned SRAM_AW   = 12,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start,
    input  logic [SRAM_AW-1:0] src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [15:0]        len_words,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SRAM_AW-1:0] sram_a,
    input  logic [31:0]        sram_do,
    output logic [3:0]         AWID,
    output logic [31:0]        AWADDR,
    output logic [3:0]         AWLEN,
    output logic [2:0]         AWSIZE,
    output logic [1:0]         AWBURST,
    output logic               AWVALID,
    input  logic               AWREADY,
    output logic [31:0]        WDATA,
    output logic [3:0]         WSTRB,
    output logic               WLAST,
    output logic               WVALID,
    input  logic               WREADY,
    input  logic [3:0]         BID,
    input  logic [1:0]         BRESP,
    input  logic               BVALID,
    output logic               BREADY
`ifdef OSW_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_cycles
`endif
);

    osw_state_e         state_q;
    logic [SRAM_AW-1:0] rd_ptr_q;
    logic [31:0]        dst_q;
    logic [15:0]        rem_q;
    logic [4:0]         beats_q;
    logic [4:0]         fetched_q;
    logic [4:0]         beat_idx_q;
    logic               inflight_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               awvalid_q;
    logic               bready_q;
    logic [31:0]        awaddr_q;
    logic [3:0]         awlen_q;

    logic [31:0]        fifo_head;
    logic [1:0]         fifo_count;
    logic               w_valid;
    logic               w_last;
    logic               w_fire;
    logic [2:0]         occ_after_pop;
    logic               rd_issue;

    logic [31:0]        nxt_dst;
    logic [15:0]        nxt_rem;
    logic [15:0]        page_room;
    logic [4:0]         nxt_beats;

    // BID is not needed (single ID); dst_addr[1:0] is forced to word alignment.
    logic               unused_in;
    assign unused_in = ^{BID, dst_addr[1:0]};

    // W beats are only offered after the AW handshake of their burst.
    assign w_valid = (state_q == W) && (fifo_count != 2'd0);
    assign w_last  = w_valid && (beat_idx_q == beats_q - 5'd1);
    assign w_fire  = w_valid && WREADY;

    // Occupancy counted after this cycle's pop so a full-rate stream keeps
    // exactly one word in flight and one in the FIFO.
    assign occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, w_fire};
    assign rd_issue      = ((state_q == AW) || (state_q == W)) &&
                           (fetched_q < beats_q) && (occ_after_pop < 3'd2);

    // Descriptor of the next burst: from the start inputs when idle, or
    // advanced past the burst just acknowledged when in B.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch.
        nxt_dst = {dst_addr[31:2], 2'b00};
        nxt_rem = len_words;
        if (state_q == B) begin
            nxt_dst = dst_q + {25'd0, beats_q, 2'b00};
            nxt_rem = rem_q - {11'd0, beats_q};
        end
        page_room = 16'd1024 - {6'd0, nxt_dst[11:2]};
        nxt_beats = 5'(min3(nxt_rem, 16'(MAX_BEATS), page_room));
    end

    osw_fifo2 #(.DW(32)) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RSTn),
        .push_i  (inflight_q),
        .data_i  (sram_do),
        .pop_i   (w_fire),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            fetched_q  <= '0;
            beat_idx_q <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            awvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_issue;
            if (rd_issue) begin
                rd_ptr_q  <= rd_ptr_q + {{(SRAM_AW-1){1'b0}}, 1'b1};
                fetched_q <= fetched_q + 5'd1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q    <= 1'b0;
                        rd_ptr_q <= src_addr;
                        dst_q    <= nxt_dst;
                        rem_q    <= nxt_rem;
                        if (len_words == 16'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= AW;
                            busy_q     <= 1'b1;
                            awvalid_q  <= 1'b1;
                            awaddr_q   <= nxt_dst;
                            awlen_q    <= 4'(nxt_beats - 5'd1);
                            beats_q    <= nxt_beats;
                            fetched_q  <= '0;
                            beat_idx_q <= '0;
                        end
                    end
                end
                AW: begin
                    if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= W;
                    end
                end
                W: begin
                    if (w_fire) begin
                        beat_idx_q <= beat_idx_q + 5'd1;
                        if (w_last) begin
                            state_q  <= B;
                            bready_q <= 1'b1;
                        end
                    end
                end
                B: begin
                    if (BVALID) begin
                        bready_q <= 1'b0;
                        if (BRESP != AXI_RESP_OKAY) err_q <= 1'b1;
                        dst_q <= nxt_dst;
                        rem_q <= nxt_rem;
                        if (nxt_rem == 16'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= AW;
                            awvalid_q  <= 1'b1;
                            awaddr_q   <= nxt_dst;
                            awlen_q    <= 4'(nxt_beats - 5'd1);
                            beats_q    <= nxt_beats;
                            fetched_q  <= '0;
                            beat_idx_q <= '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef OSW_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_cycles_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            perf_stall_q  <= '0;
            perf_cycles_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_stall_q  <= '0;
            perf_cycles_q <= '0;
        end else begin
            if ((w_valid && !WREADY) || (awvalid_q && !AWREADY)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (busy_q) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_cycles = perf_cycles_q;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign sram_a  = rd_ptr_q;
    assign AWID    = AXI_ID;
    assign AWADDR  = awaddr_q;
    assign AWLEN   = awlen_q;
    assign AWSIZE  = AXI_SIZE_4B;
    assign AWBURST = AXI_BURST_INCR;
    assign AWVALID = awvalid_q;
    assign WDATA   = fifo_head;
    assign WSTRB   = 4'hF;
    assign WLAST   = w_last;
    assign WVALID  = w_valid;
    assign BREADY  = bready_q;

endmodule

// File: tb/tb_out_sram_axi_writer.sv
// -----------------------------------------------------------------------------
// tb_out_sram_axi_writer
// Scoreboard bench: each transfer request is expanded by a reference model
// (burst list computed from address/length arithmetic) into expected AW, W
// and completion entries. A slave/monitor process plays the AXI responder
// with random backpressure and pops/compares whenever a handshake happens.
// -----------------------------------------------------------------------------
module tb_out_sram_axi_writer;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        start;
    logic [11:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy, done, err;
    logic [11:0] sram_a;
    logic [31:0] sram_do;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
`ifdef OSW_PERF_CNT_EN
    logic [31:0] perf_stall, perf_cycles;
`endif

    out_sram_axi_writer #(.MAX_BEATS(16), .SRAM_AW(12), .AXI_ID(4'd0)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len_words(len_words), .busy(busy), .done(done),
        .err(err), .sram_a(sram_a), .sram_do(sram_do), .AWID(AWID),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY), .BID(BID),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`ifdef OSW_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_cycles(perf_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    // SRAM model: registered read, data one cycle after address.
    logic [31:0] mem [4096];
    always @(posedge CLK) sram_do <= mem[sram_a];

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct { logic [31:0] addr; logic [3:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; }      w_t;

    aw_t        exp_aw_q[$];
    w_t         exp_w_q[$];
    logic       exp_done_q[$];
    logic [1:0] resp_plan_q[$];
    logic [1:0] cur_resp[$];

    int total = 0;
    int bad   = 0;

    int   pct = 100;
    logic chk_tput = 1'b0;
    int   pend_b, aw_acc, wlast_cnt, b_cnt, beat_in_burst, burst_first_cyc;
    int   done_seen = 0;
    int   w_beats = 0;
    logic b_taken, wstall_prev, awstall_prev;
    logic [31:0] wdata_prev, awaddr_prev;
    logic [3:0]  awlen_prev;
    aw_t  ea;
    w_t   ew;
    logic ed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an unexpected handshake, expected none (t=%0t)", name, $time);
    endtask

    function automatic logic roll();
        return (int'($urandom_range(0, 99)) < pct);
    endfunction

    // Reference model: split the request into 4 KB-safe bursts of at most
    // 16 beats and queue the expected AW, W and completion results.
    task automatic model_push(input logic [11:0] src, input logic [31:0] dst, input int len);
        logic [31:0] a;
        int          rem, beats, idx, nb, room;
        logic [1:0]  rsp;
        logic        e;
        a = {dst[31:2], 2'b00};
        rem = len; idx = 0; nb = 0; e = 1'b0;
        while (rem > 0) begin
            room  = (4096 - int'(a[11:0])) / 4;
            beats = rem;
            if (beats > 16)   beats = 16;
            if (beats > room) beats = room;
            exp_aw_q.push_back('{a, 4'(beats - 1)});
            for (int k = 0; k < beats; k++) begin
                exp_w_q.push_back('{mem[12'(int'(src) + idx)], (k == beats - 1)});
                idx++;
            end
            rsp = (nb < cur_resp.size()) ? cur_resp[nb] : 2'b00;
            resp_plan_q.push_back(rsp);
            if (rsp != 2'b00) e = 1'b1;
            a   = a + 32'(beats * 4);
            rem = rem - beats;
            nb++;
        end
        exp_done_q.push_back(e);
    endtask

    // AXI responder + monitor. Inputs change and handshakes are evaluated
    // 1 time unit after the falling edge; they complete at the next rise.
    initial begin : slave
        forever begin
            @(negedge CLK);
            #1;
            if (!RSTn) begin
                AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = 4'd0;
                pend_b = 0; b_taken = 1'b0; wstall_prev = 1'b0; awstall_prev = 1'b0;
                beat_in_burst = 0; aw_acc = 0; wlast_cnt = 0; b_cnt = 0;
            end else begin
                if (b_taken) begin
                    BVALID = 1'b0;
                    b_taken = 1'b0;
                end
                AWREADY = roll();
                WREADY  = roll();
                if (!BVALID && pend_b > 0 && roll()) begin
                    BVALID = 1'b1;
                    if (resp_plan_q.size() > 0) BRESP = resp_plan_q.pop_front();
                    else                        BRESP = 2'b00;
                end

                if (awstall_prev) begin
                    check("aw_valid_held", AWVALID, 1);
                    check("aw_stable", {AWADDR, AWLEN}, {awaddr_prev, awlen_prev});
                end
                if (wstall_prev) begin
                    check("w_valid_held", WVALID, 1);
                    check("w_data_stable", WDATA, wdata_prev);
                end
                awstall_prev = AWVALID && !AWREADY;
                awaddr_prev  = AWADDR;
                awlen_prev   = AWLEN;
                wstall_prev  = WVALID && !WREADY;
                wdata_prev   = WDATA;

                if (AWVALID && AWREADY) begin
                    if (exp_aw_q.size() == 0) begin
                        fail_unexpected("aw_extra");
                    end else begin
                        ea = exp_aw_q.pop_front();
                        check("awaddr", AWADDR, ea.addr);
                        check("awlen", AWLEN, ea.len);
                        check("aw_fixed", {AWID, AWSIZE, AWBURST}, {4'd0, 3'b010, 2'b01});
                    end
                    aw_acc++;
                end

                if (WVALID && WREADY) begin
                    check("w_after_aw", aw_acc > wlast_cnt, 1);
                    if (exp_w_q.size() == 0) begin
                        fail_unexpected("w_extra");
                    end else begin
                        ew = exp_w_q.pop_front();
                        check("wdata", WDATA, ew.data);
                        check("wlast", WLAST, ew.last);
                        check("wstrb", WSTRB, 4'hF);
                    end
                    if (beat_in_burst == 0) burst_first_cyc = cyc;
                    beat_in_burst++;
                    if (WLAST) begin
                        if (chk_tput) check("w_back_to_back", cyc - burst_first_cyc, beat_in_burst - 1);
                        beat_in_burst = 0;
                        wlast_cnt++;
                        pend_b++;
                    end
                    w_beats++;
                end

                if (BVALID && BREADY) begin
                    b_taken = 1'b1;
                    pend_b--;
                    b_cnt++;
                    check("b_after_wlast", b_cnt <= wlast_cnt, 1);
                end

                if (done) begin
                    check("done_busy_low", busy, 0);
                    if (exp_done_q.size() == 0) begin
                        fail_unexpected("done_extra");
                    end else begin
                        ed = exp_done_q.pop_front();
                        check("err_at_done", err, ed);
                    end
                    check("aw_all_seen", exp_aw_q.size(), 0);
                    check("w_all_seen", exp_w_q.size(), 0);
                    done_seen++;
                end
            end
        end
    end

    task automatic run(input logic [11:0] src, input logic [31:0] dst, input logic [15:0] len,
                       input int ready_pct, input logic tput, input logic spurious);
        int d0;
        int n;
        pct      = ready_pct;
        chk_tput = tput;
        model_push(src, dst, int'(len));
        d0 = done_seen;
        @(negedge CLK);
        start = 1'b1; src_addr = src; dst_addr = dst; len_words = len;
        @(negedge CLK);
        start = 1'b0; src_addr = 12'($urandom); dst_addr = $urandom; len_words = 16'($urandom);
        #2;
        if (len == 16'd0) begin
            check("len0_done_next_cycle", done, 1);
            check("len0_busy_low", busy, 0);
            check("len0_no_awvalid", AWVALID, 0);
        end else begin
            check("busy_after_start", busy, 1);
            check("err_cleared_on_start", err, 0);
        end
        n = 0;
        while (done_seen == d0 && n < 3000) begin
            @(negedge CLK);
            start = (spurious && n == 8);
            #2;
            n++;
        end
        start = 1'b0;
        check("done_within_budget", done_seen != d0, 1);
        @(negedge CLK);
        #2;
        check("done_single_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin : main
        logic [11:0] s;
        logic [31:0] d;
        int          n;

        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        RSTn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        repeat (3) @(negedge CLK);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valids", {AWVALID, WVALID, WLAST, BREADY}, 4'b0000);
        check("rst_awaddr", AWADDR, 0);
        check("rst_awlen", AWLEN, 0);
        check("rst_sram_a", sram_a, 0);
        @(negedge CLK);
        RSTn = 1'b1;

        // Single short burst, then 16/16/8 split with an ignored mid-run start.
        run(12'h010, 32'h0000_1000, 16'd5, 100, 1'b1, 1'b0);
        run(12'h000, 32'h0000_0000, 16'd40, 100, 1'b1, 1'b1);
        // 4 KB boundary split: 2 beats at 0xFF8 then 4 at 0x1000.
        run(12'h200, 32'h0000_0FF8, 16'd6, 100, 1'b1, 1'b0);
        // Random backpressure on every channel.
        run(12'h300, 32'h0000_5000, 16'd33, 50, 1'b0, 1'b0);
        // Error response on the middle burst, then a clean run clears err.
        cur_resp = '{2'b00, 2'b10, 2'b00};
        run(12'h400, 32'h0000_8000, 16'd40, 70, 1'b0, 1'b0);
        cur_resp.delete();
        run(12'h010, 32'h0000_9000, 16'd3, 100, 1'b1, 1'b0);
        run(12'h000, 32'h0000_0100, 16'd0, 100, 1'b0, 1'b0);
        // SRAM index and destination address both wrap.
        run(12'hFFC, 32'hFFFF_FFF8, 16'd6, 100, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            s = 12'($urandom);
            d = ($urandom & 32'hFFFF_F000) | (32'd4096 - 32'(4 * $urandom_range(1, 24)));
            run(s, d, 16'($urandom_range(1, 50)), 60, 1'b0, 1'b0);
        end

        // Reset in the middle of a W burst.
        pct = 100;
        chk_tput = 1'b0;
        model_push(12'h100, 32'h0000_2000, 40);
        n = w_beats;
        @(negedge CLK);
        start = 1'b1; src_addr = 12'h100; dst_addr = 32'h0000_2000; len_words = 16'd40;
        @(negedge CLK);
        start = 1'b0;
        for (int k = 0; k < 200 && w_beats < n + 5; k++) @(negedge CLK);
        check("reached_mid_burst", w_beats >= n + 5, 1);
        RSTn = 1'b0;
        exp_aw_q.delete(); exp_w_q.delete(); exp_done_q.delete(); resp_plan_q.delete();
        @(negedge CLK);
        #2;
        check("abort_valids_low", {AWVALID, WVALID, BREADY}, 3'b000);
        check("abort_busy_low", busy, 0);
        check("abort_done_low", done, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        run(12'h123, 32'h0000_3FF0, 16'd20, 100, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
